// File: rtl/cpu24_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : cpu24_fetch_if
//  Purpose  : Bundles the fetch unit's instruction-memory, redirect and
//             decode-handshake signals.
//  Ports    : master = fetch unit side, slave = memory/execute/decode side
//             imem_addr/imem_read  read request (data returns next cycle)
//             imem_data            read data
//             redirect/redirect_pc branch redirect from execute
//             instr_valid/ready    decode handshake
//             instr/instr_pc       head-of-queue instruction and its address
//  Revision : 1.0  initial release
// ============================================================================
interface cpu24_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 24
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_read;
    logic [DATA_W-1:0] imem_data;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output imem_addr, imem_read, instr_valid, instr, instr_pc,
        input  imem_data, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_addr, imem_read, instr_valid, instr, instr_pc,
        output imem_data, redirect, redirect_pc, instr_ready
    );
endinterface
`default_nettype wire

// File: rtl/cpu24_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cpu24_fetch_unit
//  Purpose  : Instruction fetch stage. Runs the PC, issues reads to a
//             synchronous instruction memory, buffers returned words in a
//             prefetch queue and hands {PC, instr} pairs to decode. A branch
//             redirect flushes queued and in-flight fetches.
//  Ports    : clk_i  rising-edge clock
//             rst_i  synchronous active-high reset
//             bus    cpu24_fetch_if.master (memory, redirect, decode signals)
//  Revision : 1.0  initial release
// ============================================================================
module cpu24_fetch_unit #(
    parameter int          ADDR_W   = 8,
    parameter int          DATA_W   = 24,
    parameter int          DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    cpu24_fetch_if.master       bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];

    logic [CNT_W:0]    occ;
    logic              issue;
    logic              push;
    logic              pop;
    logic              valid;

    // Occupancy counts the in-flight read so a response always has a slot.
    assign occ   = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
    assign issue = !rst_i && !bus.redirect && (occ < (CNT_W+1)'(DEPTH));
    // A redirect at the response edge kills the returning word.
    assign push  = inflight_q && !bus.redirect;
    assign valid = (count_q != '0);
    // Flush outranks a concurrent pop.
    assign pop   = valid && bus.instr_ready && !bus.redirect;

    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = issue;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (bus.redirect) begin
            pc_d       = bus.redirect_pc;
            inflight_d = 1'b0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (issue) begin
                pc_d  = pc_q + 1'b1;
                tag_d = pc_q;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= ADDR_W'(RESET_PC);
            tag_q      <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Queue storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_q[wr_ptr_q] <= bus.imem_data;
            addr_q[wr_ptr_q] <= tag_q;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.imem_read   = issue;
    assign bus.instr_valid = valid;
    // Outputs forced to zero when empty so reset presents Instr=0/InstrPC=0.
    assign bus.instr       = valid ? data_q[rd_ptr_q] : '0;
    assign bus.instr_pc    = valid ? addr_q[rd_ptr_q] : '0;
endmodule
`default_nettype wire

// File: tb/tb_cpu24_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu24_fetch_unit
//  Purpose  : Directed self-checking bench for cpu24_fetch_unit with a
//             synchronous instruction memory returning addr + 0x100000.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu24_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   nreads;

    always #5 clk = ~clk;

    cpu24_fetch_if #(.ADDR_W(8), .DATA_W(24)) bus ();

    cpu24_fetch_unit #(
        .ADDR_W(8), .DATA_W(24), .DEPTH(4), .RESET_PC(0)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.master)
    );

    // Synchronous instruction memory: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.imem_read)
            bus.imem_data <= 24'h100000 + {16'h0000, bus.imem_addr};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.redirect = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = 8'h00;
        bus.instr_ready = 1'b1;
        bus.imem_data   = 24'h0;
        tick();
        tick();

        // ---- 1: reset state, latency, streaming ----
        check("rst_read",  32'(bus.imem_read),   32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_addr",  32'(bus.imem_addr),   32'd0);
        check("rst_instr", 32'(bus.instr),       32'd0);
        check("rst_pc",    32'(bus.instr_pc),    32'd0);
        rst = 1'b0;
        #1;
        check("t1_issue", 32'(bus.imem_read), 32'd1);
        tick();
        check("t1_lat1", 32'(bus.instr_valid), 32'd0);
        tick();
        check("t1_valid", 32'(bus.instr_valid), 32'd1);
        check("t1_pc0",   32'(bus.instr_pc),    32'd0);
        check("t1_ins0",  32'(bus.instr),       32'h100000);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("t1_sv",  32'(bus.instr_valid), 32'd1);
            check("t1_spc", 32'(bus.instr_pc),    32'(i));
            check("t1_sin", 32'(bus.instr),       32'h100000 + 32'(i));
        end

        // ---- 2: stalled decode fills exactly DEPTH entries ----
        do_reset();
        bus.instr_ready = 1'b0;
        rst = 1'b0;
        #1;
        nreads = 0;
        for (int i = 0; i < 10; i++) begin
            nreads += int'(bus.imem_read);
            tick();
        end
        check("t2_reads",   32'(nreads),          32'd4);
        check("t2_idle",    32'(bus.imem_read),   32'd0);
        check("t2_valid",   32'(bus.instr_valid), 32'd1);
        check("t2_hold_pc", 32'(bus.instr_pc),    32'd0);
        bus.instr_ready = 1'b1;
        #1;
        for (int i = 0; i <= 5; i++) begin
            check("t2_dv",  32'(bus.instr_valid), 32'd1);
            check("t2_dpc", 32'(bus.instr_pc),    32'(i));
            tick();
        end

        // ---- 3: redirect with 3 queued + 1 in flight ----
        do_reset();
        bus.instr_ready = 1'b0;
        rst = 1'b0;
        repeat (4) tick();
        check("t3_pre_v", 32'(bus.instr_valid), 32'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h40;
        #1;
        check("t3_noissue", 32'(bus.imem_read), 32'd0);
        tick();
        bus.redirect = 1'b0;
        #1;
        check("t3_v0",   32'(bus.instr_valid), 32'd0);
        check("t3_addr", 32'(bus.imem_addr),   32'h40);
        check("t3_rd",   32'(bus.imem_read),   32'd1);
        tick();
        check("t3_v1", 32'(bus.instr_valid), 32'd0);
        tick();
        check("t3_v2",  32'(bus.instr_valid), 32'd1);
        check("t3_pc",  32'(bus.instr_pc),    32'h40);
        check("t3_ins", 32'(bus.instr),       32'h100040);
        bus.instr_ready = 1'b1;
        tick();
        check("t3_pc41", 32'(bus.instr_pc), 32'h41);
        check("t3_in41", 32'(bus.instr),    32'h100041);
        tick();
        check("t3_pc42", 32'(bus.instr_pc), 32'h42);

        // ---- 4: PC wrap from 0xFE ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'hFE;
        tick();
        bus.redirect = 1'b0;
        tick();
        check("t4_v0", 32'(bus.instr_valid), 32'd0);
        tick();
        check("t4_v1",   32'(bus.instr_valid), 32'd1);
        check("t4_pcFE", 32'(bus.instr_pc),    32'hFE);
        tick();
        check("t4_pcFF", 32'(bus.instr_pc), 32'hFF);
        tick();
        check("t4_pc00", 32'(bus.instr_pc), 32'h00);
        check("t4_in00", 32'(bus.instr),    32'h100000);
        tick();
        check("t4_pc01", 32'(bus.instr_pc), 32'h01);

        // ---- 5: back-to-back redirects, last wins ----
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h10;
        tick();
        check("t5_va", 32'(bus.instr_valid), 32'd0);
        bus.redirect_pc = 8'h20;
        #1;
        check("t5_noissue", 32'(bus.imem_read), 32'd0);
        tick();
        bus.redirect = 1'b0;
        #1;
        check("t5_vb",   32'(bus.instr_valid), 32'd0);
        check("t5_addr", 32'(bus.imem_addr),   32'h20);
        tick();
        check("t5_vc", 32'(bus.instr_valid), 32'd0);
        tick();
        check("t5_v",   32'(bus.instr_valid), 32'd1);
        check("t5_pc",  32'(bus.instr_pc),    32'h20);
        tick();
        check("t5_pc21", 32'(bus.instr_pc), 32'h21);

        // ---- 6: reset beats redirect with a full queue ----
        bus.instr_ready = 1'b0;
        repeat (6) tick();
        check("t6_full_v",  32'(bus.instr_valid), 32'd1);
        check("t6_full_rd", 32'(bus.imem_read),   32'd0);
        rst             = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h77;
        tick();
        check("t6_v",    32'(bus.instr_valid), 32'd0);
        check("t6_addr", 32'(bus.imem_addr),   32'd0);
        check("t6_rd",   32'(bus.imem_read),   32'd0);
        rst             = 1'b0;
        bus.redirect    = 1'b0;
        bus.instr_ready = 1'b1;
        #1;
        check("t6_issue", 32'(bus.imem_read), 32'd1);
        tick();
        check("t6_lat", 32'(bus.instr_valid), 32'd0);
        tick();
        check("t6_v2",  32'(bus.instr_valid), 32'd1);
        check("t6_pc",  32'(bus.instr_pc),    32'd0);
        check("t6_ins", 32'(bus.instr),       32'h100000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
